vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Parameter TICK_DIV, 4, clk cycles per pixel (100 MHz clk to 25 MHz pixel rate).
REQ-010 Port clk, input, 1, system clock; the block has this single clock domain only.
REQ-011 Port reset, input, 1, asynchronous, active-high reset.
REQ-012 Port hsync, output, 1, horizontal sync, active low.
REQ-013 Port vsync, output, 1, vertical sync, active low.
REQ-014 Port video_on, output, 1, high while the current pixel is inside the visible area; it drives the downstream RGB mux blanking select.
REQ-015 Port p_tick, output, 1, one-clk pulse marking each pixel advance.
REQ-016 Port pixel_x, output, 10, current column, 0..H_TOTAL-1.
REQ-017 Port pixel_y, output, 10, current line, 0..V_TOTAL-1.
REQ-018 Port frame_start, output, 1, one-clk pulse when the position wraps to (0,0).

Function
REQ-019 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800).
REQ-020 V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
REQ-021 A mod-TICK_DIV divider SHALL count 0..TICK_DIV-1 on every clk.
- p_tick SHALL be high only in the cycle where the divider equals TICK_DIV-1.
- At default, p_tick is high 1 cycle in every 4.
REQ-022 h_count (driving pixel_x) SHALL advance only on the clk edge where p_tick=1.
- Sequence: +1, or 0 when at H_TOTAL-1.
REQ-023 v_count (driving pixel_y) SHALL advance only on the p_tick edge where h_count wraps.
- Sequence: +1, or 0 when at V_TOTAL-1.
- With p_tick=1 and h_count<H_TOTAL-1, v_count SHALL hold.
REQ-024 hsync and vsync SHALL be registered, computed from next-state counter values, so they are cycle-aligned with pixel_x/pixel_y.
- No combinational glitches on either output.
REQ-025 hsync SHALL be 0 iff pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
- Default range: [656, 751].
REQ-026 vsync SHALL be 0 iff pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
- Default range: [490, 491].
REQ-027 video_on SHALL be combinational: (pixel_x<H_DISPLAY) && (pixel_y<V_DISPLAY) && !reset.
REQ-028 frame_start SHALL be registered and high for exactly the one clk following the p_tick edge that takes the counters from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-029 Between p_ticks, all counters and sync outputs SHALL hold their values.
REQ-030 Counter widths SHALL be 10 bits; values at or above H_TOTAL/V_TOTAL are unreachable.

Reset
REQ-031 While reset=1, the block SHALL hold:
- divider=0, pixel_x=0, pixel_y=0
- hsync=1, vsync=1
- video_on=0, p_tick=0, frame_start=0
REQ-032 Assertion of reset at any point mid-frame SHALL immediately force the REQ-031 values, independent of clk.
REQ-033 After reset deasserts, the first p_tick SHALL occur on the TICK_DIV-th clk edge, and the pixel sequence SHALL restart at (0,0).

Verification
REQ-034 Reset check: assert reset mid-frame at (300,200) -> outputs reach REQ-031 values without a clk edge; after release, p_tick first asserts on the 4th edge; pixel_x=1 after that edge.
REQ-035 Tick cadence: run 40 clks -> exactly 10 p_tick pulses, each 1 clk wide, spaced 4 clks apart.
REQ-036 Line timing: across one line -> hsync=0 for exactly 96 pixels (x=656..751); video_on=1 for x=0..639 only on y<480; at x=799 the next p_tick gives x=0 and y+1.
REQ-037 Frame timing: across one frame -> vsync=0 for exactly 2 lines (1600 p_ticks, y=490..491); video_on=0 for all of y=480..524.
REQ-038 Frame wrap: at (799,524) with p_tick -> next position (0,0); frame_start=1 for exactly 1 clk; frame period is 420000 p_ticks (1680000 clks).
REQ-039 Hold check: on clks with p_tick=0 -> pixel_x, pixel_y, hsync, vsync and video_on remain unchanged.

Source files
------------

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator (pixel tick, counters, syncs, blanking).
// Ports:
//   clk, reset           - single clock domain, asynchronous active-high reset
//   p_tick               - one-clk pulse each pixel advance (every TICK_DIV clks)
//   pixel_x, pixel_y     - current column / line position
//   hsync, vsync         - active-low syncs, registered and aligned with the position
//   video_on             - visible-area flag for the RGB blanking mux
//   frame_start          - one-clk pulse after the position wraps to (0,0)
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, tick, h_wrap;
  always_comb begin
    tick   = !reset && div_q == DIV_LAST;
    h_wrap = h_q == H_LAST;
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = tick ? (h_wrap ? '0 : h_q + 10'd1) : h_q;
    v_d    = tick && h_wrap ? (v_q == V_LAST ? '0 : v_q + 10'd1) : v_q;
    // syncs decode the next position so they land on the same edge as the counters
    hs_d   = !(h_d >= HS_LO && h_d <= HS_HI);
    vs_d   = !(v_d >= VS_LO && v_d <= VS_HI);
    fs_d   = tick && h_wrap && v_q == V_LAST;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end
  assign p_tick      = tick;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign video_on    = h_q < 10'(H_DISPLAY) && v_q < 10'(V_DISPLAY) && !reset;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: checks a default-size and a shrunken vga_sync against a position-from-time model.
module tb_vga_sync;
  logic clk = 1'b0, reset = 1'b1;
  logic d_hs, d_vs, d_vo, d_pt, d_fs, s_hs, s_vs, s_vo, s_pt, s_fs;
  logic [9:0] d_x, d_y, s_x, s_y;
  int total = 0, bad = 0, n = 0;
  bit win = 1'b0;
  int c_pt40 = 0, c_hs = 0, c_vo = 0, c_fs = 0, c_vs = 0;
  typedef struct { int x, y, pt, hs, vs, vo, fs; } exp_t;
  always #5 clk = ~clk;
  vga_sync u_def (.clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
    .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs));
  vga_sync #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_DISPLAY(4), .V_FRONT(1),
    .V_SYNC(2), .V_BACK(2), .TICK_DIV(4)) u_sm (.clk(clk), .reset(reset), .hsync(s_hs),
    .vsync(s_vs), .video_on(s_vo), .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs));
  // n = clk edges since reset released
  always @(posedge clk or posedge reset) n <= reset ? 0 : n + 1;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask
  // position follows directly from the number of pixel ticks elapsed since reset
  function automatic exp_t model(input int cnt, input int t, input int hd, input int hf,
    input int hs, input int hb, input int vd, input int vf, input int vs, input int vb, input bit r);
    exp_t e;
    int ht = hd + hf + hs + hb, vt = vd + vf + vs + vb;
    int k = cnt / t, p = k % (ht * vt);
    if (r) begin
      e = '{0, 0, 0, 1, 1, 0, 0};
      return e;
    end
    e.x  = p % ht;
    e.y  = p / ht;
    e.pt = int'(cnt % t == t - 1);
    e.hs = int'(!(e.x >= hd + hf && e.x < hd + hf + hs));
    e.vs = int'(!(e.y >= vd + vf && e.y < vd + vf + vs));
    e.vo = int'(e.x < hd && e.y < vd);
    e.fs = int'(k > 0 && p == 0 && cnt % t == 0);
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    e = model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, reset);
    chk("d_x", d_x, e.x); chk("d_y", d_y, e.y); chk("d_ptick", d_pt, e.pt);
    chk("d_hsync", d_hs, e.hs); chk("d_vsync", d_vs, e.vs); chk("d_video_on", d_vo, e.vo);
    chk("d_frame_start", d_fs, e.fs);
    e = model(n, 4, 8, 2, 3, 2, 4, 1, 2, 2, reset);
    chk("s_x", s_x, e.x); chk("s_y", s_y, e.y); chk("s_ptick", s_pt, e.pt);
    chk("s_hsync", s_hs, e.hs); chk("s_vsync", s_vs, e.vs); chk("s_video_on", s_vo, e.vo);
    chk("s_frame_start", s_fs, e.fs);
    if (win && !reset) begin
      if (n < 40) c_pt40 += int'(d_pt);
      if (n < 3200) begin
        c_hs += int'(!d_hs);
        c_vo += int'(d_vo);
      end
      if (n < 540) c_vs += int'(!s_vs);
      c_fs += int'(s_fs);
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    win = 1'b1;
    repeat (4002) @(posedge clk);
    #1 win = 1'b0;
    chk("tick_count_40clk", c_pt40, 10);
    chk("hsync_low_clks_line0", c_hs, 384);
    chk("video_on_clks_line0", c_vo, 2560);
    chk("vsync_low_clks_small_frame", c_vs, 120);
    chk("frame_start_pulses_small", c_fs, 7);
    chk("d_x_at_4002", d_x, 200); chk("d_y_at_4002", d_y, 1);
    chk("s_x_at_4002", s_x, 10); chk("s_y_at_4002", s_y, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_x", d_x, 0); chk("async_rst_y", d_y, 0);
    chk("async_rst_hs", d_hs, 1); chk("async_rst_vs", d_vs, 1);
    chk("async_rst_vo", d_vo, 0); chk("async_rst_pt", d_pt, 0);
    chk("async_rst_fs", d_fs, 0); chk("async_rst_sx", s_x, 0); chk("async_rst_sy", s_y, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("no_tick_edge2", d_pt, 0);
    @(posedge clk);
    #1 chk("first_tick_edge3", d_pt, 1);
    chk("x_before_tick", d_x, 0);
    @(posedge clk);
    #1 chk("x_after_4th_edge", d_x, 1);
    chk("tick_low_after", d_pt, 0);
    repeat (600) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
